// File: rtl/ram_burst_ctrl.sv
// Burst initiator for a single-port RAM: one word per cycle, write data from a
// valid/ready stream, read data out on a registered valid/ready stream.
module ram_burst_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_start,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_en,
  output logic              ram_rw,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, FIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                issue;

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    busy       = 1'b0;
    done       = 1'b0;
    wr_ready   = 1'b0;
    ram_en     = 1'b0;
    ram_rw     = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    issue      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          addr_d  = cmd_addr;
          // A zero length encodes a full sweep of the address space.
          rem_d   = (cmd_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, cmd_len};
          state_d = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        busy     = 1'b1;
        wr_ready = 1'b1;
        ram_en   = wr_valid;
        ram_rw   = wr_valid;
        ram_addr = addr_q;
        ram_din  = wr_data;
        if (wr_valid) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == (ADDR_W+1)'(1)) state_d = FIN;
        end
      end
      READ: begin
        busy     = 1'b1;
        ram_addr = addr_q;
        // A new read may only be issued when the output register is free or draining.
        issue    = (rem_q != '0) && (!rd_valid_q || rd_ready);
        if (issue) begin
          ram_en     = 1'b1;
          rd_data_d  = ram_dout;
          rd_valid_d = 1'b1;
          addr_d     = addr_q + 1'b1;
          rem_d      = rem_q - 1'b1;
        end else begin
          if (rd_ready) rd_valid_d = 1'b0;
          if ((rem_q == '0) && (!rd_valid_q || rd_ready)) state_d = FIN;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: cycle vector table plus directed burst sequences
// against a behavioural 256x8 RAM.
module tb_ram_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_start, cmd_write;
  logic [7:0] cmd_addr, cmd_len;
  logic       busy, done;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, rd_ready;
  logic [7:0] ram_addr, ram_din, ram_dout;
  logic       ram_en, ram_rw;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  assign ram_dout = mem[ram_addr];
  always @(posedge clk) if (ram_en && ram_rw) mem[ram_addr] <= ram_din;

  ram_burst_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_en(ram_en), .ram_rw(ram_rw),
    .ram_dout(ram_dout)
  );

  typedef struct packed {
    logic       cmd_start;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_len;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       rd_ready;
  } ins_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       wr_ready;
    logic       ram_en;
    logic       ram_rw;
    logic [7:0] ram_addr;
    logic [7:0] ram_din;
    logic       rd_valid;
    logic [7:0] rd_data;
  } outs_t;

  typedef struct {
    ins_t  in;
    outs_t exp;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t vecs [16];
  logic [7:0] aq [$];
  logic [7:0] dq [$];
  bit got_done;
  int viol;

  function automatic vec_t mk(input logic s, input logic w, input logic [7:0] a, input logic [7:0] l,
                              input logic wv, input logic [7:0] wd, input logic rr,
                              input logic b, input logic dn, input logic wrr, input logic en,
                              input logic rw, input logic [7:0] ra, input logic [7:0] din,
                              input logic rv, input logic [7:0] rd);
    vec_t v;
    v.in  = {s, w, a, l, wv, wd, rr};
    v.exp = {b, dn, wrr, en, rw, ra, din, rv, rd};
    return v;
  endfunction

  function automatic outs_t observe();
    return {busy, done, wr_ready, ram_en, ram_rw, ram_addr, ram_din, rd_valid, rd_data};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_cmd(input logic w, input logic [7:0] a, input logic [7:0] l);
    @(negedge clk);
    cmd_start = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] l, input logic [7:0] d0, input bit gaps);
    logic [7:0] n;
    aq.delete();
    got_done = 1'b0;
    n = 8'h00;
    start_cmd(1'b1, a, l);
    for (int c = 0; c < 700; c++) begin
      wr_valid = gaps ? ((c % 5) != 4) : 1'b1;
      wr_data  = d0 + n;
      #1;
      if (done) begin got_done = 1'b1; break; end
      if (ram_en && ram_rw && wr_ready) begin
        aq.push_back(ram_addr);
        n = n + 8'h01;
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    chk("wr_done_seen", 32'(got_done), 32'd1);
    @(negedge clk); #1;
    chk("wr_done_single", 32'(done), 32'd0);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] l, input bit toggle);
    dq.delete();
    got_done = 1'b0;
    viol = 0;
    start_cmd(1'b0, a, l);
    for (int c = 0; c < 700; c++) begin
      rd_ready = toggle ? (((c % 4) == 0) || ((c % 4) == 3)) : 1'b1;
      #1;
      if (done) begin got_done = 1'b1; break; end
      if (rd_valid && !rd_ready && ram_en) viol++;
      if (rd_valid && rd_ready) dq.push_back(rd_data);
      @(negedge clk);
    end
    rd_ready = 1'b0;
    chk("rd_done_seen", 32'(got_done), 32'd1);
    @(negedge clk); #1;
    chk("rd_done_single", 32'(done), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //         s  w  addr   len    wv wd     rr | b  dn wr en rw addr   din    rv rd
    vecs[0]  = mk(1, 1, 8'h10, 8'h04, 0, 8'h00, 0,  0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    vecs[1]  = mk(0, 0, 8'h00, 8'h00, 1, 8'hA0, 0,  1, 0, 1, 1, 1, 8'h10, 8'hA0, 0, 8'h00);
    vecs[2]  = mk(0, 0, 8'h00, 8'h00, 1, 8'hA1, 0,  1, 0, 1, 1, 1, 8'h11, 8'hA1, 0, 8'h00);
    vecs[3]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h77, 0,  1, 0, 1, 0, 0, 8'h12, 8'h77, 0, 8'h00);
    vecs[4]  = mk(0, 0, 8'h00, 8'h00, 1, 8'hA2, 0,  1, 0, 1, 1, 1, 8'h12, 8'hA2, 0, 8'h00);
    vecs[5]  = mk(0, 0, 8'h00, 8'h00, 1, 8'hA3, 0,  1, 0, 1, 1, 1, 8'h13, 8'hA3, 0, 8'h00);
    vecs[6]  = mk(1, 0, 8'h33, 8'h02, 1, 8'h55, 0,  0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    vecs[7]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 0,  0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    vecs[8]  = mk(1, 0, 8'h10, 8'h04, 0, 8'h00, 1,  0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
    vecs[9]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 1,  1, 0, 0, 1, 0, 8'h10, 8'h00, 0, 8'h00);
    vecs[10] = mk(1, 1, 8'h80, 8'h01, 0, 8'h00, 1,  1, 0, 0, 1, 0, 8'h11, 8'h00, 1, 8'hA0);
    vecs[11] = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 1,  1, 0, 0, 1, 0, 8'h12, 8'h00, 1, 8'hA1);
    vecs[12] = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 1,  1, 0, 0, 1, 0, 8'h13, 8'h00, 1, 8'hA2);
    vecs[13] = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 1,  1, 0, 0, 0, 0, 8'h14, 8'h00, 1, 8'hA3);
    vecs[14] = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 1,  0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'hA3);
    vecs[15] = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 1,  0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'hA3);

    rst_n = 1'b0;
    cmd_start = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_len = 8'h00;
    wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      {cmd_start, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready} = vecs[i].in;
      #1;
      chk($sformatf("vec%0d", i), 32'(observe()), 32'(vecs[i].exp));
    end
    cmd_start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;

    // Read back with a stalling consumer.
    do_read(8'h10, 8'h04, 1'b1);
    chk("tog_count", 32'(dq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < dq.size()) chk($sformatf("tog_word%0d", i), 32'(dq[i]), 32'(8'hA0 + 8'(i)));
    chk("tog_en_while_stalled", 32'(viol), 32'd0);

    // Address wrap at the top of the array.
    do_write(8'hFE, 8'h03, 8'hB0, 1'b0);
    chk("wrap_count", 32'(aq.size()), 32'd3);
    if (aq.size() == 3) begin
      chk("wrap_a0", 32'(aq[0]), 32'hFE);
      chk("wrap_a1", 32'(aq[1]), 32'hFF);
      chk("wrap_a2", 32'(aq[2]), 32'h00);
    end
    chk("wrap_memFE", 32'(mem[8'hFE]), 32'hB0);
    chk("wrap_memFF", 32'(mem[8'hFF]), 32'hB1);
    chk("wrap_mem00", 32'(mem[8'h00]), 32'hB2);

    // Zero length means a full 256-word burst, with gaps in wr_valid.
    do_write(8'h20, 8'h00, 8'h00, 1'b1);
    chk("len0_count", 32'(aq.size()), 32'd256);
    if (aq.size() == 256) begin
      chk("len0_first", 32'(aq[0]), 32'h20);
      chk("len0_last", 32'(aq[255]), 32'h1F);
    end
    chk("len0_mem25", 32'(mem[8'h25]), 32'h05);
    chk("len0_mem12", 32'(mem[8'h12]), 32'hF2);

    // Reset in the middle of a write burst after two words.
    start_cmd(1'b1, 8'h10, 8'h04);
    wr_valid = 1'b1; wr_data = 8'hD0;
    @(negedge clk);
    wr_data = 8'hD1;
    @(negedge clk);
    wr_valid = 1'b0; wr_data = 8'hD2;
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", 32'(observe()), 32'd0);
    @(negedge clk); #1;
    chk("reset_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("after_reset_idle", 32'(observe()), 32'd0);
    chk("abort_no_third", 32'(mem[8'h12]), 32'hF2);

    do_read(8'h10, 8'h02, 1'b0);
    chk("abort_rd_count", 32'(dq.size()), 32'd2);
    if (dq.size() == 2) begin
      chk("abort_rd0", 32'(dq[0]), 32'hD0);
      chk("abort_rd1", 32'(dq[1]), 32'hD1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
Initiator-side controller for the 256x8 binaryCell RAM array. It accepts a burst command from a host (base address, length, direction) and drives the RAM's address, data-in, enable and read/write pins one word per cycle. Write data arrives on a valid/ready stream; read data leaves on a valid/ready stream. It sits between the datapath/CPU and the RAM, and is the only block that drives the RAM port.

Parameters:
ADDR_W, 8, RAM address width (depth = 2^ADDR_W)
DATA_W, 8, RAM word width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cmd_start  in  1  1-cycle command strobe, accepted only when busy=0
cmd_write  in  1  1 = write burst, 0 = read burst (sampled with cmd_start)
cmd_addr  in  ADDR_W  burst base address
cmd_len  in  ADDR_W  word count; 0 encodes 2^ADDR_W (256)
busy  out  1  high from the cycle after an accepted start until done
done  out  1  1-cycle pulse when the last word is transferred
wr_data  in  DATA_W  write stream data
wr_valid  in  1  write stream valid
wr_ready  out  1  write stream ready
rd_data  out  DATA_W  read stream data (registered)
rd_valid  out  1  read stream valid
rd_ready  in  1  read stream ready
ram_addr  out  ADDR_W  to RAM address
ram_din  out  DATA_W  to RAM in
ram_en  out  1  to RAM enRAM
ram_rw  out  1  to RAM RW; 1 = write, 0 = read
ram_dout  in  DATA_W  from RAM out (combinational, valid while ram_en=1 and ram_rw=0)

Behaviour:
- Clocking: one clock, clk; rst_n asynchronous active-low. All state is updated on the rising edge of clk or cleared asynchronously on rst_n low.
- Reset values: busy=0, done=0, wr_ready=0, rd_valid=0, rd_data=0, ram_en=0, ram_rw=0, ram_addr=0, ram_din=0. State is IDLE, address counter is 0, remaining counter is 0.
- Reset mid-burst aborts the burst immediately. RAM words already written stay written. No done pulse is issued.
- State register holds IDLE, WRITE, READ or FIN.
- IDLE:
  - On cmd_start, latch addr=cmd_addr and rem = (cmd_len==0 ? 256 : cmd_len). rem is ADDR_W+1 bits.
  - Go to WRITE if cmd_write=1, else READ.
  - cmd_start while busy=1 is ignored.
- WRITE:
  - wr_ready=1.
  - ram_en=wr_valid, ram_rw=1, ram_addr=addr, ram_din=wr_data (combinational from the registers and the stream).
  - On wr_valid & wr_ready: addr+1 (mod 2^ADDR_W, so 255 wraps to 0), rem-1.
  - When the handshake consumes the last word (rem==1), go to FIN. wr_ready is 0 from the next cycle.
- READ:
  - Issue condition is rem>0 and (rd_valid==0 or rd_ready==1).
  - When issuing: ram_en=1, ram_rw=0, ram_addr=addr. At the clock edge: rd_data<=ram_dout, rd_valid<=1, addr+1 with wrap, rem-1.
  - If not issuing and rd_ready=1, clear rd_valid.
  - Throughput is 1 word/cycle with rd_ready held high. Read latency is 1 cycle from issue to rd_valid.
  - When rem==0 and the final word is accepted (rd_valid&rd_ready, or rd_valid already 0), go to FIN.
- FIN: done=1 for exactly one cycle, busy drops to 0 in the same cycle, then IDLE. A cmd_start in the FIN cycle is ignored.
- ram_en is 0 outside WRITE and READ issue cycles. ram_rw is 0 whenever ram_en is 0.
- busy is high in WRITE and READ, low in IDLE and FIN.

Test Plan:
- Write burst, addr=0x10, len=4, data A0..A3 with wr_valid held high -> ram_en=1 and ram_rw=1 for 4 consecutive cycles at addresses 10..13; done pulses the cycle after the 4th handshake.
- Read back addr=0x10, len=4, rd_ready=1 -> rd_valid high for 4 consecutive cycles, rd_data=A0,A1,A2,A3, first word 1 cycle after the first ram_en; single done pulse.
- Read with rd_ready toggling 1,0,0,1,... -> no word lost or duplicated; ram_en deasserted while rd_valid=1 and rd_ready=0.
- Write addr=0xFE, len=3 -> addresses FE, FF, 00 (wrap); len=0 write -> exactly 256 handshakes before done.
- cmd_start asserted during a busy burst -> ignored; burst length and addresses unchanged.
- rst_n low after 2 of 4 writes -> all outputs return to reset values asynchronously with no done pulse; a following read of 0x10 with len=2 returns the two written words.
